// File: rtl/adder_share_pkg.sv
// Shared types and constants for the two-requester adder-sharing arbiter.
// Optional grant statistics are enabled with ADDER_SHARE_STATS_EN.
package adder_share_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  localparam logic REQ0 = 1'b0;
  localparam logic REQ1 = 1'b1;

endpackage

// File: rtl/adder_share_arbiter_rr_arb2.sv
// Combinational two-way round-robin grant; rr_ptr picks the winner only on contention.
module rr_arb2
  import adder_share_pkg::*;
(
  input  logic valid0,
  input  logic valid1,
  input  logic rr_ptr,
  input  logic enable,
  output logic gnt0,
  output logic gnt1
);

  assign gnt0 = enable & valid0 & (~valid1 | (rr_ptr == REQ0));
  assign gnt1 = enable & valid1 & (~valid0 | (rr_ptr == REQ1));

endmodule

// File: rtl/adder_share_arbiter.sv
// Shares one external combinational add/sub unit between two valid/ready requesters.
// Define ADDER_SHARE_STATS_EN to add saturating per-requester grant counters.
module adder_share_arbiter
  import adder_share_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req0_op,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic             req1_op,
  output logic [WIDTH-1:0] add_a,
  output logic [WIDTH-1:0] add_b,
  output logic             add_op,
  input  logic [WIDTH-1:0] add_sum,
  input  logic             add_overflow,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic             resp_id,
  output logic [WIDTH-1:0] resp_sum,
  output logic             resp_overflow
`ifdef ADDER_SHARE_STATS_EN
  ,
  output logic [CNT_W-1:0] grant_cnt0,
  output logic [CNT_W-1:0] grant_cnt1
`endif
);

  state_t state_reg;
  state_t state_next;
  logic   rr_ptr;
  logic   id_reg;
  logic   gnt0;
  logic   gnt1;
  logic   hs;
  logic   winner;

  rr_arb2 u_arb (
    .valid0 (req0_valid),
    .valid1 (req1_valid),
    .rr_ptr (rr_ptr),
    .enable (state_reg == ST_IDLE),
    .gnt0   (gnt0),
    .gnt1   (gnt1)
  );

  // A grant implies valid, so a grant is the handshake itself.
  assign req0_ready = gnt0;
  assign req1_ready = gnt1;
  assign hs         = gnt0 | gnt1;
  assign winner     = gnt1 ? REQ1 : REQ0;

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: if (hs) state_next = ST_EXEC;
      ST_EXEC: state_next = ST_RESP;
      ST_RESP: if (resp_valid && resp_ready) state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= ST_IDLE;
      rr_ptr        <= REQ0;
      id_reg        <= REQ0;
      add_a         <= '0;
      add_b         <= '0;
      add_op        <= OP_ADD;
      resp_valid    <= 1'b0;
      resp_id       <= REQ0;
      resp_sum      <= '0;
      resp_overflow <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (hs) begin
        add_a  <= gnt1 ? req1_a  : req0_a;
        add_b  <= gnt1 ? req1_b  : req0_b;
        add_op <= gnt1 ? req1_op : req0_op;
        id_reg <= winner;
        rr_ptr <= ~winner;
      end
      // The adder has had a full cycle to settle from add_* when EXEC closes.
      if (state_reg == ST_EXEC) begin
        resp_sum      <= add_sum;
        resp_overflow <= add_overflow;
        resp_id       <= id_reg;
        resp_valid    <= 1'b1;
      end else if (state_reg == ST_RESP && resp_ready) begin
        resp_valid <= 1'b0;
      end
    end
  end

`ifdef ADDER_SHARE_STATS_EN
  logic [1:0] gnt_vec;
  assign gnt_vec = {gnt1, gnt0};

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : gen_cnt
      logic [CNT_W-1:0] cnt_reg;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          cnt_reg <= '0;
        end else if (gnt_vec[gi] && (cnt_reg != {CNT_W{1'b1}})) begin
          cnt_reg <= cnt_reg + 1'b1;
        end
      end
    end
  endgenerate

  assign grant_cnt0 = gen_cnt[0].cnt_reg;
  assign grant_cnt1 = gen_cnt[1].cnt_reg;
`endif

endmodule

// File: tb/tb_adder_share_arbiter.sv
// Randomised and directed bench for adder_share_arbiter against a transaction-level model.
module tb_adder_share_arbiter;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       req0_valid, req0_ready, req0_op;
  logic [7:0] req0_a, req0_b;
  logic       req1_valid, req1_ready, req1_op;
  logic [7:0] req1_a, req1_b;
  logic [7:0] add_a, add_b, add_sum;
  logic       add_op, add_overflow;
  logic       resp_valid, resp_ready, resp_id, resp_overflow;
  logic [7:0] resp_sum;
`ifdef ADDER_SHARE_STATS_EN
  logic [15:0] grant_cnt0, grant_cnt1;
`endif

  always #5 clk = ~clk;

  adder_share_arbiter #(.WIDTH(8), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
    .add_a(add_a), .add_b(add_b), .add_op(add_op), .add_sum(add_sum), .add_overflow(add_overflow),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id),
    .resp_sum(resp_sum), .resp_overflow(resp_overflow)
`ifdef ADDER_SHARE_STATS_EN
    , .grant_cnt0(grant_cnt0), .grant_cnt1(grant_cnt1)
`endif
  );

  // External shared adder.
  assign add_sum      = add_op ? add_a - add_b : add_a + add_b;
  assign add_overflow = add_op ? ((add_a[7] != add_b[7]) && (add_sum[7] != add_a[7]))
                               : ((add_a[7] == add_b[7]) && (add_sum[7] != add_a[7]));

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic ref_alu(input logic [7:0] a, input logic [7:0] b, input logic op,
                         output logic [7:0] s, output logic o);
    int sa, sb, r;
    sa = int'($signed(a));
    sb = int'($signed(b));
    r  = op ? sa - sb : sa + sb;
    s  = r[7:0];
    o  = (r > 127) || (r < -128);
  endtask

  // Transaction-level model: 0 = free, after a grant one settle cycle, then a held response.
  int         m_wait;
  logic       m_rv, m_rr, m_pid, m_povf, m_rid, m_rovf, m_op;
  logic [7:0] m_a, m_b, m_psum, m_rsum;
  logic       e_g0, e_g1, e_idle;
  int         gnt_log[$];
  int         m_cnt0, m_cnt1;

  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_resp_valid", 32'(resp_valid), 32'd0);
      chk("rst_add_a", 32'(add_a), 32'd0);
      chk("rst_add_b", 32'(add_b), 32'd0);
      chk("rst_add_op", 32'(add_op), 32'd0);
      chk("rst_resp_id", 32'(resp_id), 32'd0);
      chk("rst_resp_sum", 32'(resp_sum), 32'd0);
      chk("rst_resp_ovf", 32'(resp_overflow), 32'd0);
`ifdef ADDER_SHARE_STATS_EN
      chk("rst_cnt0", 32'(grant_cnt0), 32'd0);
      chk("rst_cnt1", 32'(grant_cnt1), 32'd0);
`endif
      m_wait = 0; m_rv = 0; m_rr = 0; m_op = 0; m_a = 0; m_b = 0;
      m_rid = 0; m_rsum = 0; m_rovf = 0; m_cnt0 = 0; m_cnt1 = 0;
      gnt_log.delete();
    end else begin
      e_idle = (m_wait == 0) && !m_rv;
      e_g0 = e_idle && req0_valid && (!req1_valid || m_rr == 1'b0);
      e_g1 = e_idle && req1_valid && (!req0_valid || m_rr == 1'b1);
      chk("req0_ready", 32'(req0_ready), 32'(e_g0));
      chk("req1_ready", 32'(req1_ready), 32'(e_g1));
      chk("add_a", 32'(add_a), 32'(m_a));
      chk("add_b", 32'(add_b), 32'(m_b));
      chk("add_op", 32'(add_op), 32'(m_op));
      chk("resp_valid", 32'(resp_valid), 32'(m_rv));
      if (m_rv) begin
        chk("resp_id", 32'(resp_id), 32'(m_rid));
        chk("resp_sum", 32'(resp_sum), 32'(m_rsum));
        chk("resp_ovf", 32'(resp_overflow), 32'(m_rovf));
      end
`ifdef ADDER_SHARE_STATS_EN
      chk("grant_cnt0", 32'(grant_cnt0), 32'(m_cnt0));
      chk("grant_cnt1", 32'(grant_cnt1), 32'(m_cnt1));
`endif
      // Advance the model across the coming rising edge.
      if (m_rv && resp_ready) m_rv = 0;
      if (m_wait > 0) begin
        m_wait = m_wait - 1;
        if (m_wait == 0) begin
          m_rv = 1; m_rid = m_pid; m_rsum = m_psum; m_rovf = m_povf;
        end
      end
      if (e_g0 || e_g1) begin
        m_pid = e_g1;
        m_a   = e_g1 ? req1_a : req0_a;
        m_b   = e_g1 ? req1_b : req0_b;
        m_op  = e_g1 ? req1_op : req0_op;
        ref_alu(m_a, m_b, m_op, m_psum, m_povf);
        m_rr  = ~e_g1;
        m_wait = 1;
        gnt_log.push_back(e_g1 ? 1 : 0);
        if (e_g0 && m_cnt0 < 65535) m_cnt0++;
        if (e_g1 && m_cnt1 < 65535) m_cnt1++;
      end
    end
  end

  task automatic set_req(input logic id, input logic [7:0] a, input logic [7:0] b, input logic op);
    if (id) begin req1_valid = 1; req1_a = a; req1_b = b; req1_op = op; end
    else    begin req0_valid = 1; req0_a = a; req0_b = b; req0_op = op; end
  endtask

  // Issue one request from the current posedge+1 point and collect its response.
  task automatic do_op(input string name, input logic id, input logic [7:0] a, input logic [7:0] b,
                       input logic op, input logic [7:0] exp_sum, input logic exp_ovf);
    bit got = 0;
    int lat = 0;
    set_req(id, a, b, op);
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      got = id ? (req1_valid && req1_ready) : (req0_valid && req0_ready);
    end
    chk({name, "_handshake"}, 32'(got), 32'd1);
    if (got) begin
      got = 0;
      for (int i = 0; i < 10 && !got; i++) begin
        @(negedge clk);
        lat++;
        got = resp_valid;
      end
      chk({name, "_latency"}, 32'(lat), 32'd2);
      chk({name, "_sum"}, 32'(resp_sum), 32'(exp_sum));
      chk({name, "_ovf"}, 32'(resp_overflow), 32'(exp_ovf));
      chk({name, "_id"}, 32'(resp_id), 32'(id));
    end
    @(posedge clk); #1;
    req0_valid = 0; req1_valid = 0;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
  endtask

  initial begin
    bit h0, h1, ok, alt;
    req0_valid = 0; req0_a = 0; req0_b = 0; req0_op = 0;
    req1_valid = 0; req1_a = 0; req1_b = 0; req1_op = 0;
    resp_ready = 1;
    repeat (3) @(posedge clk);
    #1 rst_n = 1;

    do_op("t1_add", 1'b0, 8'h01, 8'h01, 1'b0, 8'h02, 1'b0);
    do_op("t2_sub", 1'b1, 8'h01, 8'h01, 1'b1, 8'h00, 1'b0);
    do_op("t4_addovf", 1'b0, 8'h7F, 8'h01, 1'b0, 8'h80, 1'b1);
    do_op("t4_subovf", 1'b0, 8'h80, 8'h01, 1'b1, 8'h7F, 1'b1);

    // Both requesters continuously valid from reset.
    do_reset();
    set_req(1'b0, 8'($urandom), 8'($urandom), 1'($urandom));
    set_req(1'b1, 8'($urandom), 8'($urandom), 1'($urandom));
    for (int i = 0; i < 24; i++) begin
      @(negedge clk);
      h0 = req0_valid && req0_ready;
      h1 = req1_valid && req1_ready;
      @(posedge clk); #1;
      if (h0) set_req(1'b0, 8'($urandom), 8'($urandom), 1'($urandom));
      if (h1) set_req(1'b1, 8'($urandom), 8'($urandom), 1'($urandom));
    end
    req0_valid = 0; req1_valid = 0;
    repeat (4) @(posedge clk);
    #1;
    chk("t3_grant_count_ge4", 32'(gnt_log.size() >= 4), 32'd1);
    if (gnt_log.size() >= 4) begin
      chk("t3_grant0", 32'(gnt_log[0]), 32'd0);
      chk("t3_grant1", 32'(gnt_log[1]), 32'd1);
      chk("t3_grant2", 32'(gnt_log[2]), 32'd0);
      chk("t3_grant3", 32'(gnt_log[3]), 32'd1);
    end
    alt = 1;
    for (int i = 1; i < gnt_log.size(); i++) if (gnt_log[i] == gnt_log[i-1]) alt = 0;
    chk("t3_alternating", 32'(alt), 32'd1);

    // Response back-pressure with requester 1 waiting.
    resp_ready = 0;
    set_req(1'b0, 8'h10, 8'h20, 1'b0);
    ok = 0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      ok = req0_valid && req0_ready;
    end
    chk("t5_handshake", 32'(ok), 32'd1);
    @(posedge clk); #1;
    req0_valid = 0;
    set_req(1'b1, 8'h05, 8'h03, 1'b1);
    ok = 0;
    for (int i = 0; i < 10 && !ok; i++) begin
      @(negedge clk);
      ok = resp_valid;
    end
    chk("t5_resp_seen", 32'(ok), 32'd1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("t5_hold_valid", 32'(resp_valid), 32'd1);
      chk("t5_hold_sum", 32'(resp_sum), 32'h30);
      chk("t5_req1_blocked", 32'(req1_ready), 32'd0);
    end
    @(posedge clk); #1 resp_ready = 1;
    @(negedge clk);
    chk("t5_no_same_cycle_accept", 32'(req1_ready), 32'd0);
    @(negedge clk);
    chk("t5_accept_next_cycle", 32'(req1_ready), 32'd1);
    @(posedge clk); #1 req1_valid = 0;
    repeat (4) @(posedge clk);
    #1;

    // Reset asserted while the adder is in its settle cycle.
    set_req(1'b0, 8'h33, 8'h44, 1'b0);
    ok = 0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      ok = req0_valid && req0_ready;
    end
    chk("t6_handshake", 32'(ok), 32'd1);
    @(posedge clk); #1;
    rst_n = 0;
    req0_valid = 0;
    #1;
    chk("t6_async_resp_valid", 32'(resp_valid), 32'd0);
    chk("t6_async_add_a", 32'(add_a), 32'd0);
    chk("t6_async_add_b", 32'(add_b), 32'd0);
    chk("t6_async_resp_sum", 32'(resp_sum), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("t6_dropped", 32'(resp_valid), 32'd0);
    end

    // Randomised traffic with random back-pressure.
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      h0 = req0_valid && req0_ready;
      h1 = req1_valid && req1_ready;
      @(posedge clk); #1;
      if (!req0_valid || h0) begin
        req0_valid = ($urandom_range(0, 99) < 60);
        req0_a = 8'($urandom); req0_b = 8'($urandom); req0_op = 1'($urandom);
      end
      if (!req1_valid || h1) begin
        req1_valid = ($urandom_range(0, 99) < 60);
        req1_a = 8'($urandom); req1_b = 8'($urandom); req1_op = 1'($urandom);
      end
      resp_ready = ($urandom_range(0, 99) < 70);
    end
    @(negedge clk);
    @(posedge clk); #1;
    req0_valid = 0; req1_valid = 0; resp_ready = 1;
    repeat (6) @(posedge clk);
    #1;
    chk("final_idle", 32'(resp_valid), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/adder_share_arbiter.md
Name: adder_share_arbiter

Overview:
- Shares one external combinational 8-bit add/subtract unit between two requesters.
- Each requester uses a valid/ready request channel (a, b, op); results return on one registered response channel tagged with the requester id.
- Round-robin arbitration. Sits between the CPU datapath and a secondary client, such as an address-increment unit, in the mini CPU.

Parameters:
- WIDTH, 8, operand/result width; must match the shared adder.
- CNT_W, 16, width of per-requester grant counters (optional feature only).

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- req0_valid  in  1  requester 0 has an operation
- req0_ready  out  1  requester 0 accepted this cycle
- req0_a  in  WIDTH  requester 0 operand a
- req0_b  in  WIDTH  requester 0 operand b
- req0_op  in  1  0 = a+b, 1 = a-b
- req1_valid, req1_ready, req1_a, req1_b, req1_op  same as requester 0, for requester 1
- add_a  out  WIDTH  registered operand a to shared adder
- add_b  out  WIDTH  registered operand b to shared adder
- add_op  out  1  registered op to shared adder
- add_sum  in  WIDTH  shared adder result (combinational from add_*)
- add_overflow  in  1  shared adder signed overflow
- resp_valid  out  1  result available
- resp_ready  in  1  consumer accepts result
- resp_id  out  1  requester that issued the result
- resp_sum  out  WIDTH  captured result
- resp_overflow  out  1  captured overflow
- grant_cnt0, grant_cnt1  out  CNT_W  only when ADDER_SHARE_STATS_EN is defined

Behaviour:
- FSM states: IDLE, EXEC, RESP. Reset state is IDLE.
- Reset values: add_a = add_b = 0, add_op = 0, resp_valid = 0, resp_id = 0, resp_sum = 0, resp_overflow = 0, rr_ptr = 0, counters = 0.
- Reset mid-operation: any in-flight transaction is dropped without a response. The requester must reissue.

IDLE state:
- reqN_ready = 1 only for the granted requester. The other requester sees ready = 0. Both readys are 0 outside IDLE.
- Grant rule when both valid: grant = rr_ptr.
- Grant rule when only one valid: grant that one.
- When neither is valid, there is no grant.
- On a handshake (valid & ready) at edge N:
  - the winner's a, b, op latch into add_a, add_b, add_op;
  - the winner's id latches internally;
  - rr_ptr <= ~winner;
  - next state is EXEC.

EXEC state:
- Lasts exactly one cycle; the adder settles from registered inputs.
- At the closing edge: resp_sum <= add_sum, resp_overflow <= add_overflow, resp_id <= latched id, resp_valid <= 1, then go to RESP.

RESP state:
- resp_* are held stable while resp_valid = 1 and resp_ready = 0.
- On resp_valid & resp_ready: resp_valid <= 0 and go to IDLE.
- A new request cannot be accepted in the same cycle as the response handshake.

Timing and data rules:
- Latency is 2 cycles from request handshake to resp_valid.
- Maximum throughput is one operation per 3 cycles.
- Requests must hold valid and operands stable until ready. The block does not buffer a second request.
- Arithmetic is entirely in the shared adder: two's complement, WIDTH-bit wrap-around, overflow = signed overflow. The block never modifies results.
- add_* retain their last value outside EXEC; the adder output is only sampled in EXEC.

Optional Feature:
- Macro: ADDER_SHARE_STATS_EN.
- When defined:
  - grant_cnt0 and grant_cnt1 ports exist.
  - Each counter increments on its requester's handshake and saturates at all-ones (no wrap).
  - Counters reset to 0.
- When undefined: the ports and counters are absent, and the rest of the behaviour is identical.

Decomposition:
- Shared package adder_share_pkg holds:
  - state encoding constants ST_IDLE = 2'd0, ST_EXEC = 2'd1, ST_RESP = 2'd2;
  - OP_ADD = 1'b0, OP_SUB = 1'b1;
  - REQ0 = 1'b0, REQ1 = 1'b1.
- Sub-module rr_arb2: a purely combinational two-way round-robin grant.
  - Inputs: valid0, valid1, rr_ptr, enable.
  - Outputs: gnt0, gnt1.
- The top level owns the FSM, registers, rr_ptr and the optional counters.

Test Plan:
1. After reset, req0: a = 8'h01, b = 8'h01, op = 0, resp_ready = 1 -> resp_valid 2 cycles after handshake; resp_sum = 8'h02, resp_overflow = 0, resp_id = 0.
2. req1 only: a = 8'h01, b = 8'h01, op = 1 -> resp_sum = 8'h00, overflow = 0, resp_id = 1.
3. Both valid continuously from reset, with varied operands -> grants alternate 0, 1, 0, 1; no requester is granted twice in a row while the other waits.
4. Overflow cases: req0 with 8'h7F + 8'h01 -> resp_sum = 8'h80, overflow = 1. req0 with 8'h80 - 8'h01 -> resp_sum = 8'h7F, overflow = 1.
5. Hold resp_ready = 0 for 5 cycles with req1 pending -> resp_* stay stable and req1_ready stays 0. After resp_ready = 1, req1 is accepted no earlier than the following cycle.
6. Assert rst_n = 0 during EXEC -> resp_valid = 0 and all outputs at reset values immediately, with no response. With ADDER_SHARE_STATS_EN defined, grant_cnt0 = grant_cnt1 = 0 after reset.
